fwrisc_wb_arbiter: RTL and testbench

2:1 Wishbone arbiter that merges the fwrisc_wb instruction port (t0) and data port (t1) onto one Wishbone initiator port, so the core can share a single bus slot. Round-robin on contention; a grant is held until the transaction completes. A watchdog completes stalled transactions so the core cannot hang, and records a sticky error flag.

---
 rtl/fwrisc_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_fwrisc_wb_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_wb_arbiter.sv
// 2:1 Wishbone arbiter: merges the fwrisc instruction (t0) and data (t1) ports
// onto one initiator port, round-robin on ties, with a stall watchdog.
module fwrisc_wb_arbiter #(
  parameter int ADR_W   = 32,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [ADR_W-1:0]   t0_adr,
  input  logic               t0_cyc,
  input  logic               t0_stb,
  output logic [DAT_W-1:0]   t0_dat_r,
  output logic               t0_ack,
  input  logic [ADR_W-1:0]   t1_adr,
  input  logic [DAT_W-1:0]   t1_dat_w,
  input  logic [DAT_W/8-1:0] t1_sel,
  input  logic               t1_we,
  input  logic               t1_cyc,
  input  logic               t1_stb,
  output logic [DAT_W-1:0]   t1_dat_r,
  output logic               t1_ack,
  output logic [ADR_W-1:0]   i_adr,
  output logic [DAT_W-1:0]   i_dat_w,
  output logic [DAT_W/8-1:0] i_sel,
  output logic               i_we,
  output logic               i_cyc,
  output logic               i_stb,
  input  logic [DAT_W-1:0]   i_dat_r,
  input  logic               i_ack,
  output logic               tmo_err,
  input  logic               tmo_clr
);

  // A zero-width counter is illegal, so a disabled watchdog still keeps one bit.
  localparam int  CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit  TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_err_q, tmo_err_d;
  logic             tmo_set;
  logic             req0, req1, tmo_hit;

  assign req0    = t0_cyc & t0_stb;
  assign req1    = t1_cyc & t1_stb;
  assign tmo_hit = TMO_EN && (cnt_q == CNT_W'(TIMEOUT));
  assign tmo_err = tmo_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b0;
      cnt_q      <= '0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = '0;
    tmo_set    = 1'b0;
    i_adr      = '0;
    i_dat_w    = '0;
    i_sel      = '0;
    i_we       = 1'b0;
    i_cyc      = 1'b0;
    i_stb      = 1'b0;
    t0_dat_r   = '0;
    t1_dat_r   = '0;
    t0_ack     = 1'b0;
    t1_ack     = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, last_gnt_q names the port that must wait this time.
        if (req1 && (!req0 || !last_gnt_q)) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end else if (req0) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end
      end

      GNT0: begin
        i_adr    = t0_adr;
        i_cyc    = t0_cyc;
        i_stb    = t0_stb;
        t0_dat_r = i_dat_r;
        t1_dat_r = i_dat_r;
        if (!t0_cyc) begin
          state_d = IDLE;
        end else if (i_ack) begin
          t0_ack  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          t0_ack   = 1'b1;
          t0_dat_r = '0;
          i_cyc    = 1'b0;
          i_stb    = 1'b0;
          tmo_set  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GNT1: begin
        i_adr    = t1_adr;
        i_dat_w  = t1_dat_w;
        i_sel    = t1_sel;
        i_we     = t1_we;
        i_cyc    = t1_cyc;
        i_stb    = t1_stb;
        t0_dat_r = i_dat_r;
        t1_dat_r = i_dat_r;
        if (!t1_cyc) begin
          state_d = IDLE;
        end else if (i_ack) begin
          t1_ack  = 1'b1;
          state_d = IDLE;
        end else if (tmo_hit) begin
          t1_ack   = 1'b1;
          t1_dat_r = '0;
          i_cyc    = 1'b0;
          i_stb    = 1'b0;
          tmo_set  = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A watchdog firing in the same cycle as a clear keeps the flag set.
    if (tmo_set)      tmo_err_d = 1'b1;
    else if (tmo_clr) tmo_err_d = 1'b0;
    else              tmo_err_d = tmo_err_q;
  end

endmodule

// File: tb/tb_fwrisc_wb_arbiter.sv
// Directed bench for fwrisc_wb_arbiter: reads, round-robin ties, writes,
// watchdog, abort and asynchronous reset, with hand-computed expectations.
module tb_fwrisc_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] t0_adr;
  logic        t0_cyc, t0_stb;
  logic [31:0] t0_dat_r;
  logic        t0_ack;
  logic [31:0] t1_adr, t1_dat_w;
  logic [3:0]  t1_sel;
  logic        t1_we, t1_cyc, t1_stb;
  logic [31:0] t1_dat_r;
  logic        t1_ack;
  logic [31:0] i_adr, i_dat_w;
  logic [3:0]  i_sel;
  logic        i_we, i_cyc, i_stb;
  logic [31:0] i_dat_r;
  logic        i_ack;
  logic        tmo_err, tmo_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  fwrisc_wb_arbiter #(.ADR_W(32), .DAT_W(32), .TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .t0_adr(t0_adr), .t0_cyc(t0_cyc), .t0_stb(t0_stb),
    .t0_dat_r(t0_dat_r), .t0_ack(t0_ack),
    .t1_adr(t1_adr), .t1_dat_w(t1_dat_w), .t1_sel(t1_sel), .t1_we(t1_we),
    .t1_cyc(t1_cyc), .t1_stb(t1_stb), .t1_dat_r(t1_dat_r), .t1_ack(t1_ack),
    .i_adr(i_adr), .i_dat_w(i_dat_w), .i_sel(i_sel), .i_we(i_we),
    .i_cyc(i_cyc), .i_stb(i_stb), .i_dat_r(i_dat_r), .i_ack(i_ack),
    .tmo_err(tmo_err), .tmo_clr(tmo_clr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".i_cyc"},    {63'd0, i_cyc}, 64'd0);
    chk({tag, ".i_stb"},    {63'd0, i_stb}, 64'd0);
    chk({tag, ".i_we"},     {63'd0, i_we}, 64'd0);
    chk({tag, ".i_adr"},    {32'd0, i_adr}, 64'd0);
    chk({tag, ".i_dat_w"},  {32'd0, i_dat_w}, 64'd0);
    chk({tag, ".i_sel"},    {60'd0, i_sel}, 64'd0);
    chk({tag, ".acks"},     {62'd0, t0_ack, t1_ack}, 64'd0);
    chk({tag, ".dat_r"},    {t0_dat_r, t1_dat_r}, 64'd0);
    chk({tag, ".tmo_err"},  {63'd0, tmo_err}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; tmo_clr = 1'b0;
    t0_adr = '0; t0_cyc = 0; t0_stb = 0;
    t1_adr = '0; t1_dat_w = '0; t1_sel = '0; t1_we = 0; t1_cyc = 0; t1_stb = 0;
    i_dat_r = 32'hCAFE_0001; i_ack = 0;

    // Reset state
    step(); step();
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Single t0 read, target acks two cycles after i_cyc rises
    step();
    t0_adr = 32'h100; t0_cyc = 1; t0_stb = 1;
    #1 chk("rd.idle_cyc", {63'd0, i_cyc}, 64'd0);
    step(); #1;
    chk("rd.gnt_cyc", {62'd0, i_cyc, i_stb}, 64'd3);
    chk("rd.adr", {32'd0, i_adr}, 64'h100);
    chk("rd.we", {63'd0, i_we}, 64'd0);
    step(); #1;
    chk("rd.wait_ack", {62'd0, t0_ack, t1_ack}, 64'd0);
    step();
    i_ack = 1; i_dat_r = 32'hDEADBEEF;
    #1;
    chk("rd.t0_ack", {63'd0, t0_ack}, 64'd1);
    chk("rd.t0_dat_r", {32'd0, t0_dat_r}, 64'hDEADBEEF);
    chk("rd.t1_ack", {63'd0, t1_ack}, 64'd0);
    step();
    i_ack = 0;
    #1 chk("rd.dead_idle", {63'd0, i_cyc}, 64'd0);
    t0_cyc = 0; t0_stb = 0;

    // Tie, round-robin: expected grant order t1,t0,t1,t0
    step();
    t0_adr = 32'hA0; t0_cyc = 1; t0_stb = 1;
    t1_adr = 32'hB0; t1_cyc = 1; t1_stb = 1; t1_we = 1;
    for (int k = 0; k < 4; k++) begin
      automatic logic exp_t1 = (k % 2 == 0);
      #1 chk($sformatf("rr%0d.idle", k), {63'd0, i_cyc}, 64'd0);
      step(); #1;
      chk($sformatf("rr%0d.adr", k), {32'd0, i_adr}, exp_t1 ? 64'hB0 : 64'hA0);
      chk($sformatf("rr%0d.we", k), {63'd0, i_we}, {63'd0, exp_t1});
      i_ack = 1;
      #1 chk($sformatf("rr%0d.acks", k), {62'd0, t0_ack, t1_ack},
             exp_t1 ? 64'd1 : 64'd2);
      step();
      i_ack = 0;
    end
    t0_cyc = 0; t0_stb = 0; t1_cyc = 0; t1_stb = 0; t1_we = 0;

    // t1 write forwarded unchanged
    step();
    t1_adr = 32'h2000_0004; t1_dat_w = 32'h12345678; t1_sel = 4'h3; t1_we = 1;
    t1_cyc = 1; t1_stb = 1;
    step(); #1;
    chk("wr.adr", {32'd0, i_adr}, 64'h2000_0004);
    chk("wr.dat_w", {32'd0, i_dat_w}, 64'h12345678);
    chk("wr.sel_we", {59'd0, i_sel, i_we}, 64'h7);
    i_ack = 1;
    #1 chk("wr.acks", {62'd0, t0_ack, t1_ack}, 64'd1);
    step();
    i_ack = 0; t1_cyc = 0; t1_stb = 0; t1_we = 0;

    // Watchdog: TIMEOUT=4, target never acks, fires on the 5th grant cycle
    step();
    t1_adr = 32'h300; t1_cyc = 1; t1_stb = 1; i_dat_r = 32'hAAAA5555;
    for (int c = 1; c <= 4; c++) begin
      step(); #1;
      chk($sformatf("wd.c%0d", c), {61'd0, i_cyc, t1_ack, tmo_err}, 64'h4);
    end
    step(); #1;
    chk("wd.fire_ack", {63'd0, t1_ack}, 64'd1);
    chk("wd.fire_dat", {32'd0, t1_dat_r}, 64'd0);
    chk("wd.fire_cyc", {62'd0, i_cyc, i_stb}, 64'd0);
    step(); #1;
    chk("wd.err_set", {63'd0, tmo_err}, 64'd1);
    chk("wd.idle", {63'd0, i_cyc}, 64'd0);
    t1_cyc = 0; t1_stb = 0;
    step(); #1;
    chk("wd.err_sticky", {63'd0, tmo_err}, 64'd1);
    tmo_clr = 1;
    step(); #1;
    tmo_clr = 0;
    chk("wd.err_clr", {63'd0, tmo_err}, 64'd0);

    // Abort: t0 drops cyc one cycle into the grant; a same-cycle ack is dropped
    step();
    t0_adr = 32'h400; t0_cyc = 1; t0_stb = 1;
    step(); #1;
    chk("ab.gnt", {63'd0, i_cyc}, 64'd1);
    step();
    t0_cyc = 0; t0_stb = 0; i_ack = 1;
    #1;
    chk("ab.cyc_drop", {63'd0, i_cyc}, 64'd0);
    chk("ab.no_ack", {62'd0, t0_ack, t1_ack}, 64'd0);
    step();
    i_ack = 0; t0_cyc = 1; t0_stb = 1;
    #1 chk("ab.idle", {63'd0, i_cyc}, 64'd0);
    t0_cyc = 0; t0_stb = 0;

    // Reset mid-GNT1, then a tie must go to t1 again
    step();
    t1_adr = 32'h500; t1_dat_w = 32'h55; t1_sel = 4'hF; t1_we = 1;
    t1_cyc = 1; t1_stb = 1; i_dat_r = 32'h1234_5678;
    step(); #1;
    chk("rst.gnt1", {62'd0, i_cyc, i_we}, 64'd3);
    reset_n = 0;
    #1 chk_all_zero("rst.async");
    step();
    reset_n = 1;
    t0_adr = 32'hA0; t0_cyc = 1; t0_stb = 1; t1_adr = 32'hB0;
    step(); #1;
    chk("rst.tie_adr", {32'd0, i_adr}, 64'hB0);
    chk("rst.tie_we", {63'd0, i_we}, 64'd1);
    t0_cyc = 0; t0_stb = 0; t1_cyc = 0; t1_stb = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always ends even if the stimulus stalls.
  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench time limit reached");
  end

endmodule
